// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM encoding, BCD limits,
// counter widths and the load-validation helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alarm_state_e;

  localparam logic [7:0] BCD_HH_MIN = 8'h01;
  localparam logic [7:0] BCD_HH_MAX = 8'h12;
  localparam logic [7:0] BCD_MM_MAX = 8'h59;

  localparam int SNOOZE_W = 13;
  localparam int RING_W   = 12;

  function automatic logic bcd_byte_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Nibble checks also reject 8'h0A..8'h0F, which the numeric range alone would pass.
  function automatic logic alarm_time_ok(input logic [7:0] h, input logic [7:0] m);
    return bcd_byte_ok(h) && bcd_byte_ok(m) &&
           (h >= BCD_HH_MIN) && (h <= BCD_HH_MAX) && (m <= BCD_MM_MAX);
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter advanced by the 1 Hz tick; done flags the tick
// that drains the last remaining second.
module alarm_sec_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  input  logic         ena,
  output logic         done
);

  logic [W-1:0] count_r;

  // Load wins over counting; the count holds at zero instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (run && ena && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry: this tick takes the counter from one to zero.
  always_comb begin
    done = run && ena && (count_r == {{(W-1){1'b0}}, 1'b1});
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller for a 12-hour BCD clock: stores the alarm time, rings on the
// alarm minute, supports snooze, stop and auto-stop.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  input  logic       alarm_on,
  input  logic       set_alarm,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       alarm_pm,
  output logic       ring,
  output logic       armed,
  output logic       snoozing,
  output logic       set_err
);

  localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD = SNOOZE_W'(SNOOZE_MIN * 60);
  localparam logic [RING_W-1:0]   RING_LOAD   = RING_W'(RING_SEC);

  alarm_state_e state_r;
  alarm_state_e next_state_s;
  logic [7:0]   alarm_hh_r;
  logic [7:0]   alarm_mm_r;
  logic         alarm_pm_r;
  logic         ring_r;
  logic         armed_r;
  logic         snoozing_r;
  logic         set_err_r;
  logic         match_s;
  logic         match_d_r;
  logic         trigger_s;
  logic         load_ok_s;
  logic         ring_load_s;
  logic         snz_load_s;
  logic         ring_done_s;
  logic         snz_done_s;

  // Alarm-minute detection; the rising edge gives exactly one trigger per minute.
  always_comb begin
    match_s   = (hh == alarm_hh_r) && (mm == alarm_mm_r) &&
                (ss == 8'h00) && (pm == alarm_pm_r);
    trigger_s = match_s && !match_d_r;
    load_ok_s = alarm_time_ok(set_hh, set_mm);
  end

  // Next-state decode; alarm_on=0 beats stop, which beats snooze, which beats expiry.
  always_comb begin
    next_state_s = state_r;
    if (!alarm_on) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = ST_ARMED;
        ST_ARMED: begin
          if (trigger_s) next_state_s = ST_RINGING;
          else           next_state_s = ST_ARMED;
        end
        ST_RINGING: begin
          if (stop)             next_state_s = ST_ARMED;
          else if (snooze)      next_state_s = ST_SNOOZE;
          else if (ring_done_s) next_state_s = ST_ARMED;
          else                  next_state_s = ST_RINGING;
        end
        ST_SNOOZE: begin
          if (stop)            next_state_s = ST_ARMED;
          else if (snz_done_s) next_state_s = ST_RINGING;
          else                 next_state_s = ST_SNOOZE;
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
    ring_load_s = (next_state_s == ST_RINGING) && (state_r != ST_RINGING);
    snz_load_s  = (next_state_s == ST_SNOOZE) && (state_r != ST_SNOOZE);
  end

  alarm_sec_timer #(.W(RING_W)) u_ring_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (ring_load_s),
    .load_val (RING_LOAD),
    .run      (state_r == ST_RINGING),
    .ena      (ena),
    .done     (ring_done_s)
  );

  alarm_sec_timer #(.W(SNOOZE_W)) u_snooze_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (snz_load_s),
    .load_val (SNOOZE_LOAD),
    .run      (state_r == ST_SNOOZE),
    .ena      (ena),
    .done     (snz_done_s)
  );

  // State register with outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ring_r     <= 1'b0;
      armed_r    <= 1'b0;
      snoozing_r <= 1'b0;
      match_d_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      ring_r     <= (next_state_s == ST_RINGING);
      armed_r    <= (next_state_s == ST_ARMED);
      snoozing_r <= (next_state_s == ST_SNOOZE);
      match_d_r  <= match_s;
    end
  end

  // Alarm time storage; loads are independent of the FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hh_r <= 8'h12;
      alarm_mm_r <= 8'h00;
      alarm_pm_r <= 1'b0;
      set_err_r  <= 1'b0;
    end else begin
      set_err_r <= set_alarm && !load_ok_s;
      if (set_alarm && load_ok_s) begin
        alarm_hh_r <= set_hh;
        alarm_mm_r <= set_mm;
        alarm_pm_r <= set_pm;
      end else begin
        alarm_hh_r <= alarm_hh_r;
        alarm_mm_r <= alarm_mm_r;
        alarm_pm_r <= alarm_pm_r;
      end
    end
  end

  assign alarm_hh = alarm_hh_r;
  assign alarm_mm = alarm_mm_r;
  assign alarm_pm = alarm_pm_r;
  assign ring     = ring_r;
  assign armed    = armed_r;
  assign snoozing = snoozing_r;
  assign set_err  = set_err_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: a seconds-of-day reference model predicts
// every cycle's outputs, a monitor compares them after each clock edge.
module tb_alarm_ctrl;

  localparam int SNOOZE_MIN = 9;
  localparam int RING_SEC   = 60;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;
  localparam int PM_0629_59 = 18 * 3600 + 29 * 60 + 59;
  localparam int AM_0629_59 = 6 * 3600 + 29 * 60 + 59;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] hh = 8'h12, mm = 8'h00, ss = 8'h00;
  logic       pm = 1'b0;
  logic       alarm_on = 1'b0;
  logic       set_alarm = 1'b0;
  logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
  logic       set_pm = 1'b0;
  logic       snooze = 1'b0, stop = 1'b0;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_pm, ring, armed, snoozing, set_err;

  always #5 clk = ~clk;

  alarm_ctrl #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .alarm_on(alarm_on), .set_alarm(set_alarm), .set_hh(set_hh), .set_mm(set_mm),
    .set_pm(set_pm), .snooze(snooze), .stop(stop), .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm), .alarm_pm(alarm_pm), .ring(ring), .armed(armed),
    .snoozing(snoozing), .set_err(set_err)
  );

  int n_checks = 0;
  int n_errs = 0;
  logic [20:0] exp_q[$];

  // Reference model: wall time as seconds of day, alarm as plain integers.
  int tsec = 0;
  bit on_lvl = 1'b0;
  bit rst_lvl = 1'b0;
  int m_mode = M_IDLE, m_ticks = 0, m_ah = 12, m_am = 0;
  bit m_prev = 1'b0, m_apm = 1'b0, m_err = 1'b0;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic int hour12(input int t);
    int h;
    h = (t / 3600) % 12;
    return (h == 0) ? 12 : h;
  endfunction

  function automatic logic [20:0] model_out();
    return {m_mode == M_RING, m_mode == M_ARMED, m_mode == M_SNOOZE, m_err,
            to_bcd(m_ah), to_bcd(m_am), m_apm};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock cycle of stimulus: drive at the falling edge, predict, enqueue.
  task automatic drive(input bit e, input bit snz, input bit stp, input bit sa,
                       input logic [7:0] shh, input logic [7:0] smm, input bit spm);
    int h12, mi, se, hv, mv;
    bit tpm, match, trig, ok;
    @(negedge clk);
    h12 = hour12(tsec);
    mi  = (tsec / 60) % 60;
    se  = tsec % 60;
    tpm = (tsec / 3600) >= 12;
    reset = rst_lvl; alarm_on = on_lvl;
    ena = e; snooze = snz; stop = stp;
    set_alarm = sa; set_hh = shh; set_mm = smm; set_pm = spm;
    hh = to_bcd(h12); mm = to_bcd(mi); ss = to_bcd(se); pm = tpm;
    if (!rst_lvl) begin
      m_mode = M_IDLE; m_ticks = 0; m_prev = 1'b0;
      m_ah = 12; m_am = 0; m_apm = 1'b0; m_err = 1'b0;
    end else begin
      match = (h12 == m_ah) && (mi == m_am) && (se == 0) && (tpm == m_apm);
      trig = match && !m_prev;
      m_prev = match;
      if (!on_lvl) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE:  m_mode = M_ARMED;
          M_ARMED: if (trig) begin m_mode = M_RING; m_ticks = 0; end
          M_RING: begin
            if (stp) m_mode = M_ARMED;
            else if (snz) begin m_mode = M_SNOOZE; m_ticks = 0; end
            else if (e) begin
              m_ticks++;
              if (m_ticks == RING_SEC) m_mode = M_ARMED;
            end
          end
          M_SNOOZE: begin
            if (stp) m_mode = M_ARMED;
            else if (e) begin
              m_ticks++;
              if (m_ticks == SNOOZE_MIN * 60) begin m_mode = M_RING; m_ticks = 0; end
            end
          end
          default: m_mode = M_IDLE;
        endcase
      end
      ok = (int'(shh[7:4]) <= 9) && (int'(shh[3:0]) <= 9) &&
           (int'(smm[7:4]) <= 9) && (int'(smm[3:0]) <= 9);
      hv = int'(shh[7:4]) * 10 + int'(shh[3:0]);
      mv = int'(smm[7:4]) * 10 + int'(smm[3:0]);
      ok = ok && (hv >= 1) && (hv <= 12) && (mv <= 59);
      m_err = sa && !ok;
      if (sa && ok) begin m_ah = hv; m_am = mv; m_apm = spm; end
    end
    exp_q.push_back(model_out());
    if (e) tsec = (tsec + 1) % 86400;
  endtask

  task automatic tick(input bit e);
    drive(e, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Walk the clock across the alarm minute so one trigger occurs.
  task automatic hit_alarm(input int start);
    tsec = start;
    tick(1'b1);
    tick(1'b0);
    settle();
  endtask

  // Monitor: each expected entry is checked just after the edge it belongs to.
  always @(posedge clk) begin : monitor
    logic [20:0] exp_v, got_v;
    #2;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      got_v = {ring, armed, snoozing, set_err, alarm_hh, alarm_mm, alarm_pm};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errs++;
        $display("FAIL outputs t=%0t got=%h exp=%h", $time, got_v, exp_v);
      end
    end
  end

  initial begin : stim
    bit e, snz, stp, sa, spm;
    logic [7:0] shh, smm;
    int asec;

    repeat (3) tick(1'b0);
    settle();
    chk("reset_ring", {7'd0, ring}, 8'd0);
    chk("reset_alarm_hh", alarm_hh, 8'h12);
    rst_lvl = 1'b1;

    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 8'h00, 1'b0);
    settle();
    chk("bad_hh_err", {7'd0, set_err}, 8'd1);
    chk("bad_hh_keep", alarm_hh, 8'h12);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h5A, 1'b1);
    settle();
    chk("bad_mm_err", {7'd0, set_err}, 8'd1);
    chk("bad_mm_keep", alarm_mm, 8'h00);
    tick(1'b0);
    settle();
    chk("err_one_cycle", {7'd0, set_err}, 8'd0);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 8'h30, 1'b1);
    on_lvl = 1'b1;
    tick(1'b0);
    settle();
    chk("load_hh", alarm_hh, 8'h06);
    chk("armed", {7'd0, armed}, 8'd1);

    tsec = PM_0629_59;
    tick(1'b1);
    settle();
    chk("no_ring_early", {7'd0, ring}, 8'd0);
    tick(1'b0);
    settle();
    chk("ring_on_match", {7'd0, ring}, 8'd1);
    repeat (3) tick(1'b0);
    settle();
    chk("ring_holds", {7'd0, ring}, 8'd1);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    chk("snoozing", {6'd0, snoozing, ring}, 8'd2);
    repeat (SNOOZE_MIN * 60 - 1) tick(1'b1);
    settle();
    chk("snooze_not_done", {7'd0, ring}, 8'd0);
    tick(1'b1);
    settle();
    chk("snooze_rering", {7'd0, ring}, 8'd1);

    repeat (RING_SEC - 1) tick(1'b1);
    settle();
    chk("ring_before_auto", {7'd0, ring}, 8'd1);
    tick(1'b1);
    settle();
    chk("auto_stop", {6'd0, armed, ring}, 8'd2);

    hit_alarm(AM_0629_59);
    tick(1'b0);
    settle();
    chk("am_no_ring", {7'd0, ring}, 8'd0);

    hit_alarm(PM_0629_59);
    chk("ring_again", {7'd0, ring}, 8'd1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    chk("stop_beats_snooze", {6'd0, armed, snoozing}, 8'd2);

    hit_alarm(PM_0629_59);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    settle();
    chk("snooze2", {7'd0, snoozing}, 8'd1);
    on_lvl = 1'b0;
    tick(1'b1);
    settle();
    chk("off_to_idle", {6'd0, armed, snoozing}, 8'd0);

    on_lvl = 1'b1;
    tick(1'b0);
    hit_alarm(PM_0629_59);
    chk("ring_pre_reset", {7'd0, ring}, 8'd1);
    reset = 1'b0;
    rst_lvl = 1'b0;
    #1;
    chk("async_ring", {7'd0, ring}, 8'd0);
    chk("async_hh", alarm_hh, 8'h12);
    chk("async_pm", {7'd0, alarm_pm}, 8'd0);
    repeat (2) tick(1'b0);
    rst_lvl = 1'b1;
    tick(1'b0);

    for (int i = 0; i < 4000; i++) begin
      asec = ((m_apm ? 12 : 0) + (m_ah % 12)) * 3600 + m_am * 60;
      if ($urandom_range(0, 249) == 0) tsec = (asec - int'($urandom_range(1, 3)) + 86400) % 86400;
      on_lvl = ($urandom_range(0, 399) != 0);
      e   = ($urandom_range(0, 3) != 0);
      snz = ($urandom_range(0, 199) == 0);
      stp = ($urandom_range(0, 399) == 0);
      sa  = ($urandom_range(0, 199) == 0);
      spm = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        shh = to_bcd(int'($urandom_range(1, 12)));
        smm = to_bcd(int'($urandom_range(0, 59)));
      end else begin
        shh = 8'($urandom);
        smm = 8'($urandom);
      end
      drive(e, snz, stp, sa, shh, smm, spm);
    end
    settle();
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
